// File: rtl/uart_pkg.sv
// Shared constants and receiver state encoding for the 9N1 UART pair.
package uart_pkg;

  localparam int DATA_BITS            = 9;
  localparam int DEFAULT_CLKS_PER_BIT = 434;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, with selectable reset value.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // NOTE: synchronous reset lives inside the clocked block; it is sampled only on a clock edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 9N1 UART receiver: mid-bit sampling FSM with valid/ack handoff, framing and overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ack,
  output logic                 busy,
  output logic                 framing_error,
  output logic                 overrun
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic                 rx_s;
  logic                 rx_prev_q;
  rx_state_e            state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [IDX_W-1:0]     idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 busy_q;
  logic                 fe_q;
  logic                 ov_q;

  // Preset high so a reset never looks like a start-bit edge.
  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clock (clock),
    .reset (reset),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
      rx_prev_q <= 1'b1;
    end else begin
      rx_prev_q <= rx_s;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
      // NOTE: the last non-blocking assignment wins, so a word landing in STOP overrides this clear.
      if (valid_q && ack) valid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (!rx_s && rx_prev_q) begin
            state_q <= START;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (cnt_q == CNT_HALF) begin
            cnt_q <= '0;
            if (!rx_s) begin
              idx_q   <= '0;
              state_q <= DATA;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == CNT_FULL) begin
            cnt_q          <= '0;
            shift_q[idx_q] <= rx_s;
            idx_q          <= idx_q + 1'b1;
            if (idx_q == IDX_LAST) state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == CNT_FULL) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
            if (rx_s) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
              ov_q    <= valid_q && !ack;
            end else begin
              fe_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign data          = data_q;
  assign valid         = valid_q;
  assign busy          = busy_q;
  assign framing_error = fe_q;
  assign overrun       = ov_q;

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clock cycles per serial bit; legal values are 4 or more.
REQ-002 clock  input  1  system clock; all logic on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 rx  input  1  asynchronous serial line; idle high; 9N1 framing, LSB first.
REQ-005 data  output  9  last received word; stable while valid=1.
REQ-006 valid  output  1  high while data holds an unconsumed word.
REQ-007 ack  input  1  consumer handshake; valid&&ack consumes the word.
REQ-008 busy  output  1  high whenever the FSM is not in IDLE.
REQ-009 framing_error  output  1  one-cycle pulse when the stop bit samples as 0.
REQ-010 overrun  output  1  one-cycle pulse when an unconsumed word is overwritten.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer before any use; rx_s denotes the synchronized value.
REQ-012 The FSM SHALL have exactly the states IDLE, START, DATA and STOP.
REQ-013 IDLE: on an rx_s 1->0 transition (rx_s=0 with the previous rx_s=1), the FSM SHALL clear the bit counter and go to START; a line held low never starts a frame.
REQ-014 START: when bit counter = CLKS_PER_BIT/2-1 (integer division), the FSM SHALL sample rx_s.
  - rx_s=0: clear the counter, clear the bit index, go to DATA.
  - rx_s=1: treat as a glitch and return to IDLE with no output activity.
REQ-015 DATA: at counter = CLKS_PER_BIT-1, the FSM SHALL shift rx_s into bit[index], clear the counter and increment the index; after index 8 is sampled, go to STOP.
REQ-016 STOP: at counter = CLKS_PER_BIT-1 (mid stop bit), the FSM SHALL sample rx_s and go to IDLE in the same cycle.
  - rx_s=1: load data from the shift register and set valid on the next cycle.
  - rx_s=0: pulse framing_error for one cycle; discard the word; data and valid are unchanged.
REQ-017 The bit counter SHALL be $clog2(CLKS_PER_BIT) bits wide, SHALL hold 0 in IDLE, and SHALL never exceed CLKS_PER_BIT-1.
REQ-018 valid SHALL rise at the latest 10.5*CLKS_PER_BIT+4 cycles after the rx falling edge of the start bit.
REQ-019 valid SHALL clear on the cycle after valid&&ack, unless REQ-021 applies; ack while valid=0 SHALL be ignored.
REQ-020 A word completes with valid=1 and ack=0: data SHALL be overwritten, valid SHALL stay 1, and overrun SHALL pulse for one cycle.
REQ-021 A word completes in the same cycle as valid&&ack: the new data SHALL be loaded, valid SHALL stay 1, and no overrun SHALL occur.
REQ-022 busy SHALL equal (state != IDLE), registered.
REQ-023 Back-to-back frames with no idle gap between the stop bit and the next start bit SHALL be received without loss.

Reset
REQ-024 When reset=1, the block SHALL enter IDLE with: counter, index and shift register all 0; data=0; valid=0; busy=0; framing_error=0; overrun=0.
REQ-025 Reset SHALL preset both synchronizer flops to 1.
REQ-026 Reset asserted mid-frame SHALL abandon the frame with no valid or error pulse; reception resumes at the next 1->0 edge after reset deasserts.

Structure
REQ-027 Package uart_pkg SHALL hold DATA_BITS=9, DEFAULT_CLKS_PER_BIT=434 and the rx state enum; uart_tx SHALL use the same package.
REQ-028 The synchronizer SHALL be a separate sub-module, sync_2ff, parameterized by reset value; all other logic lives in uart_rx.

Verification (CLKS_PER_BIT=16 for all scenarios)
REQ-029 Loopback: uart_tx sends 9'h155, consumer acks immediately -> valid pulses exactly once, data=9'h155, framing_error=0, overrun=0.
REQ-030 Glitch: rx low for 4 cycles, then high -> FSM returns to IDLE; valid, framing_error and busy stay low after the glitch.
REQ-031 Framing error: 9'h0AA sent with stop bit 0 -> framing_error pulses 1 cycle near 10.5*16 cycles after the start edge; valid stays 0.
REQ-032 Overrun and simultaneous ack:
  - 9'h001 then 9'h1FF back-to-back, no ack -> overrun pulses once, data=9'h1FF, valid=1.
  - Repeat with ack asserted on the cycle the second word completes -> no overrun.
REQ-033 Reset mid-frame: reset asserted during bit 4 of 9'h0F0, then 9'h123 sent -> only 9'h123 is received; no error pulses.
